// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame loader feeding the descending sorting network.
// Two ping-pong banks let one frame fill while the other waits for the network.
module sort_frame_loader #(
  parameter int NETWORK_WIDTH = 16,
  parameter int INDEX_WIDTH   = 3,
  parameter int NETWORK_SIZE  = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [NETWORK_WIDTH-1:0]              in_data,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NETWORK_SIZE*NETWORK_WIDTH-1:0] out_data,
  output logic [NETWORK_SIZE*INDEX_WIDTH-1:0]   out_index,
  output logic [INDEX_WIDTH:0]                  out_count
);

  logic [NETWORK_WIDTH-1:0] r_mem [2][NETWORK_SIZE];
  logic [INDEX_WIDTH:0]     r_count [2];
  logic [1:0]               r_full;
  logic                     r_wr_bank;
  logic                     r_rd_bank;
  logic [INDEX_WIDTH-1:0]   r_wr_ptr;

  logic w_accept;
  logic w_complete;
  logic w_pop;

  assign in_ready   = !r_full[r_wr_bank] && !flush;
  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept &&
                      ((r_wr_ptr == INDEX_WIDTH'(NETWORK_SIZE - 1)) || in_last);
  assign out_valid  = r_full[r_rd_bank];
  assign w_pop      = out_valid && out_ready;
  assign out_count  = r_count[r_rd_bank];

  // Sample storage carries no reset; stale lanes are hidden by the count mask.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_bank][r_wr_ptr] <= in_data;
    end
  end

  // Accept and pop always address different banks, so both may apply together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= '0;
      r_count[0] <= '0;
      r_count[1] <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_ptr   <= '0;
    end else if (flush) begin
      r_full     <= '0;
      r_count[0] <= '0;
      r_count[1] <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_complete) begin
        r_full[r_wr_bank]  <= 1'b1;
        r_count[r_wr_bank] <= {1'b0, r_wr_ptr} + (INDEX_WIDTH+1)'(1);
        r_wr_bank          <= !r_wr_bank;
        r_wr_ptr           <= '0;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + INDEX_WIDTH'(1);
      end
      if (w_pop) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= !r_rd_bank;
      end
    end
  end

  // Pad lanes read as zero so they sink to the bottom of a descending sort.
  always_comb begin
    out_data  = '0;
    out_index = '0;
    for (int unsigned i = 0; i < NETWORK_SIZE; i++) begin
      if ((INDEX_WIDTH+1)'(i) < r_count[r_rd_bank]) begin
        out_data[i*NETWORK_WIDTH +: NETWORK_WIDTH] = r_mem[r_rd_bank][i];
      end
      out_index[i*INDEX_WIDTH +: INDEX_WIDTH] = INDEX_WIDTH'(i);
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed self-checking bench for sort_frame_loader (16-bit samples, 8 lanes).
module tb_sort_frame_loader;

  localparam int W  = 16;
  localparam int IW = 3;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [N*W-1:0]  out_data;
  logic [N*IW-1:0] out_index;
  logic [IW:0]     out_count;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [N*IW-1:0] exp_idx;
  logic [N*W-1:0]  exp_data;

  sort_frame_loader #(
    .NETWORK_WIDTH (W),
    .INDEX_WIDTH   (IW),
    .NETWORK_SIZE  (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Lane i = first + i*inc for i < n, zero above.
  function automatic logic [N*W-1:0] lin(input int unsigned first, input int unsigned inc,
                                         input int unsigned n);
    logic [N*W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v[i*W +: W] = W'(first + i*inc);
    return v;
  endfunction

  task automatic drive(input logic v, input int unsigned d, input logic last);
    in_valid = v;
    in_data  = W'(d);
    in_last  = last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 0, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_count !== 4'd0) $display("FAIL reset_out_count got=%0d exp=0", out_count); else n_pass++;
    n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else n_pass++;
    n_checks++; if (out_index !== exp_idx) $display("FAIL reset_out_index got=%h exp=%h", out_index, exp_idx); else n_pass++;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_stream8();
    int unsigned ready_bad = 0;
    out_ready = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      drive(1'b1, (k+1)*10, 1'b0);
      if (in_ready !== 1'b1) ready_bad++;
      if (k == 7) begin
        n_checks++; if (out_valid !== 1'b0) $display("FAIL s8_early_valid got=%b exp=0", out_valid); else n_pass++;
      end
      step();
    end
    drive(1'b0, 0, 1'b0);
    n_checks++; if (ready_bad != 0) $display("FAIL s8_in_ready low_cycles=%0d exp=0", ready_bad); else n_pass++;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL s8_out_valid got=%b exp=1", out_valid); else n_pass++;
    exp_data = lin(10, 10, 8);
    n_checks++; if (out_data !== exp_data) $display("FAIL s8_out_data got=%h exp=%h", out_data, exp_data); else n_pass++;
    n_checks++; if (out_index !== exp_idx) $display("FAIL s8_out_index got=%h exp=%h", out_index, exp_idx); else n_pass++;
    n_checks++; if (out_count !== 4'd8) $display("FAIL s8_out_count got=%0d exp=8", out_count); else n_pass++;
    step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL s8_consumed got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_last();
    out_ready = 1'b0;
    drive(1'b1, 5, 1'b0); step();
    drive(1'b1, 9, 1'b0); step();
    drive(1'b1, 7, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    exp_data = '0;
    exp_data[0*W +: W] = 16'd5;
    exp_data[1*W +: W] = 16'd9;
    exp_data[2*W +: W] = 16'd7;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL last_out_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (out_count !== 4'd3) $display("FAIL last_out_count got=%0d exp=3", out_count); else n_pass++;
    n_checks++; if (out_data !== exp_data) $display("FAIL last_out_data got=%h exp=%h", out_data, exp_data); else n_pass++;
    n_checks++; if (out_index !== exp_idx) $display("FAIL last_out_index got=%h exp=%h", out_index, exp_idx); else n_pass++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // in_last on the final lane is an ordinary full frame.
    for (int unsigned k = 0; k < 8; k++) begin
      drive(1'b1, 300 + k, k == 7); step();
    end
    drive(1'b0, 0, 1'b0);
    exp_data = lin(300, 1, 8);
    n_checks++; if (out_count !== 4'd8) $display("FAIL last8_out_count got=%0d exp=8", out_count); else n_pass++;
    n_checks++; if (out_data !== exp_data) $display("FAIL last8_out_data got=%h exp=%h", out_data, exp_data); else n_pass++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int unsigned unstable = 0;
    int unsigned ready_bad = 0;
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      drive(1'b1, k + 1, 1'b0);
      if (in_ready !== 1'b1) ready_bad++;
      step();
      if (k >= 7 && (out_valid !== 1'b1 || out_data !== lin(1, 1, 8) || out_count !== 4'd8)) unstable++;
    end
    n_checks++; if (ready_bad != 0) $display("FAIL bp_in_ready_fill low_cycles=%0d exp=0", ready_bad); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL bp_hold_stable bad_cycles=%0d exp=0", unstable); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got=%b exp=0", in_ready); else n_pass++;
    drive(1'b1, 77, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    exp_data = lin(1, 1, 8);
    n_checks++; if (out_data !== exp_data) $display("FAIL bp_ignored_sample got=%h exp=%h", out_data, exp_data); else n_pass++;
    out_ready = 1'b1; step(); out_ready = 1'b0;
    exp_data = lin(9, 1, 8);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_second_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_data) $display("FAIL bp_second_data got=%h exp=%h", out_data, exp_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_rise got=%b exp=1", in_ready); else n_pass++;
    out_ready = 1'b1; step();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drained got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned frames = 0;
    int unsigned ready_bad = 0;
    logic        exp_v;
    out_ready = 1'b1;
    for (int unsigned c = 0; c < 41; c++) begin
      if (c < 40) drive(1'b1, 100 + c, 1'b0);
      else        drive(1'b0, 0, 1'b0);
      if (c < 40 && in_ready !== 1'b1) ready_bad++;
      step();
      exp_v = (c % 8 == 7);
      n_checks++;
      if (out_valid !== exp_v) $display("FAIL b2b_valid cycle=%0d got=%b exp=%b", c, out_valid, exp_v);
      else n_pass++;
      if (exp_v) begin
        exp_data = lin(100 + frames*8, 1, 8);
        n_checks++;
        if (out_data !== exp_data || out_count !== 4'd8)
          $display("FAIL b2b_frame%0d got=%h/%0d exp=%h/8", frames, out_data, out_count, exp_data);
        else n_pass++;
        frames++;
      end
    end
    n_checks++; if (ready_bad != 0) $display("FAIL b2b_in_ready low_cycles=%0d exp=0", ready_bad); else n_pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 13; k++) begin
      drive(1'b1, 50 + k, 1'b0); step();
    end
    drive(1'b0, 0, 1'b0);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_pending got=%b exp=1", out_valid); else n_pass++;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rm_in_ready got=%b exp=1", in_ready); else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    for (int unsigned k = 0; k < 8; k++) begin
      drive(1'b1, 200 + k, 1'b0); step();
    end
    drive(1'b0, 0, 1'b0);
    exp_data = lin(200, 1, 8);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL rm_fresh_valid got=%b exp=1", out_valid); else n_pass++;
    n_checks++; if (out_data !== exp_data) $display("FAIL rm_fresh_data got=%h exp=%h", out_data, exp_data); else n_pass++;
    n_checks++; if (out_index !== exp_idx) $display("FAIL rm_fresh_index got=%h exp=%h", out_index, exp_idx); else n_pass++;
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      drive(1'b1, 20 + k, 1'b0); step();
    end
    flush = 1'b1;
    drive(1'b1, 99, 1'b0);
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fl_in_ready_during got=%b exp=0", in_ready); else n_pass++;
    step();
    flush = 1'b0;
    drive(1'b0, 0, 1'b0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL fl_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_count !== 4'd0) $display("FAIL fl_out_count got=%0d exp=0", out_count); else n_pass++;
    drive(1'b1, 50, 1'b1); step();
    drive(1'b0, 0, 1'b0);
    exp_data = lin(50, 0, 1);
    n_checks++; if (out_count !== 4'd1) $display("FAIL fl_next_count got=%0d exp=1", out_count); else n_pass++;
    n_checks++; if (out_data !== exp_data) $display("FAIL fl_next_lane0 got=%h exp=%h", out_data, exp_data); else n_pass++;
    out_ready = 1'b1; step();
  endtask

  initial begin
    for (int unsigned i = 0; i < N; i++) exp_idx[i*IW +: IW] = IW'(i);
    test_reset();
    test_stream8();
    test_last();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
